led_breathe_pwm: RTL and testbench

Downstream consumer of the board's slow-tick counter. It takes a single-cycle tick strobe and drives one LED with a "breathing" brightness profile using PWM. Brightness ramps up, holds, ramps down and holds, forever. It sits between the free-running prescaler and the LED pin on the Arty A7 top level.

---
 rtl/led_breathe_pwm.sv | 78 +++++++
 tb/tb_led_breathe_pwm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_breathe_pwm.sv
// led_breathe_pwm: tick-driven breathing LED (ramp up, hold, ramp down, hold) rendered as PWM.
// Brightness advances one level per STEP_DIV ticks; en=0 freezes everything and blanks the LED.
module led_breathe_pwm #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 16,
  parameter int HOLD_TOP = 4,
  parameter int HOLD_BOT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                tick,
  output logic                led,
  output logic [PWM_BITS-1:0] level,
  output logic [1:0]          state
);
  localparam int DW = $clog2(STEP_DIV + 1);
  localparam int HMAX = HOLD_TOP > HOLD_BOT ? HOLD_TOP : HOLD_BOT;
  localparam int HW = $clog2(HMAX + 1);
  localparam logic [PWM_BITS-1:0] MAXL = '1;
  typedef enum logic [1:0] {HOLD_LO = 2'd0, RISE = 2'd1, HOLD_HI = 2'd2, FALL = 2'd3} state_t;
  if (STEP_DIV < 1 || HOLD_TOP < 1 || HOLD_BOT < 1) begin : g_bad_params
    $error("led_breathe_pwm: STEP_DIV, HOLD_TOP and HOLD_BOT must all be >= 1");
  end
  state_t              state_q;
  logic [PWM_BITS-1:0] level_q, pwm_q, pwm_d;
  logic [DW-1:0]       div_q, div_d;
  logic [HW-1:0]       hold_q;
  logic                led_q, led_d, div_wrap, step;
  always_comb begin
    div_wrap = div_q == DW'(STEP_DIV - 1);
    step     = en && tick && div_wrap;
    div_d    = tick ? (div_wrap ? '0 : div_q + 1'b1) : div_q;
    pwm_d    = pwm_q + 1'b1;
    led_d    = en && (pwm_q < level_q);
  end
  // Hold counters share one register; it is always zero on entry to either hold state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HOLD_LO;
      level_q <= '0;
      pwm_q   <= '0;
      div_q   <= '0;
      hold_q  <= '0;
      led_q   <= 1'b0;
    end else begin
      led_q <= led_d;
      if (en) begin
        pwm_q <= pwm_d;
        div_q <= div_d;
        if (step) begin
          case (state_q)
            HOLD_LO: if (hold_q == HW'(HOLD_BOT - 1)) begin
              hold_q  <= '0;
              state_q <= RISE;
            end else hold_q <= hold_q + 1'b1;
            RISE: if (level_q == MAXL - 1'b1) begin
              level_q <= MAXL;
              state_q <= HOLD_HI;
            end else level_q <= level_q + 1'b1;
            HOLD_HI: if (hold_q == HW'(HOLD_TOP - 1)) begin
              hold_q  <= '0;
              state_q <= FALL;
            end else hold_q <= hold_q + 1'b1;
            FALL: if (level_q == PWM_BITS'(1)) begin
              level_q <= '0;
              state_q <= HOLD_LO;
            end else level_q <= level_q - 1'b1;
            default: state_q <= HOLD_LO;
          endcase
        end
      end
    end
  end
  assign led   = led_q;
  assign level = level_q;
  assign state = state_q;
endmodule

// File: tb/tb_led_breathe_pwm.sv
// tb_led_breathe_pwm: randomized and directed checks of led_breathe_pwm against a closed-form model.
// The model derives level/state from the count of enabled ticks and led from the count of enabled clocks.
module tb_led_breathe_pwm;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, tick = 1'b0;
  logic led;
  logic [3:0] level;
  logic [1:0] state;
  int vectors = 0, errors = 0;
  int m_clks = 0, m_ticks = 0;
  logic m_led = 1'b0;
  always #5 clk = ~clk;
  led_breathe_pwm #(.PWM_BITS(4), .STEP_DIV(2), .HOLD_TOP(2), .HOLD_BOT(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .led(led), .level(level), .state(state)
  );
  // One breathe period is 34 steps: 2 low holds, 15 rise, 2 high holds, 15 fall.
  function automatic logic [5:0] ref_ls(input int ticks);
    int k;
    k = (ticks / 2) % 34;
    if (k < 2) return {4'd0, 2'd0};
    if (k < 17) return {4'(k - 2), 2'd1};
    if (k < 19) return {4'd15, 2'd2};
    return {4'(34 - k), 2'd3};
  endfunction
  function automatic logic [6:0] expv();
    return {m_led, ref_ls(m_ticks)};
  endfunction
  task automatic cyc(input logic e, input logic t);
    logic [5:0] ls;
    en = e;
    tick = t;
    @(posedge clk);
    if (!rst_n) begin
      m_clks = 0;
      m_ticks = 0;
      m_led = 1'b0;
    end else begin
      ls = ref_ls(m_ticks);
      m_led = e && ((m_clks % 16) < int'(ls[5:2]));
      if (e) begin
        m_clks++;
        if (t) m_ticks++;
      end
    end
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    do_reset();
    repeat (100) begin
      cyc(1'b1, 1'b1);
      vectors++;
      if ({led, level, state} !== expv()) begin
        errors++;
        $display("FAIL reset_run got=%h exp=%h", {led, level, state}, expv());
      end
    end
    rst_n = 1'b0;
    repeat (3) begin
      cyc(1'b1, 1'b1);
      vectors++;
      if ({led, level, state} !== 7'd0) begin
        errors++;
        $display("FAIL reset_hold got=%h exp=00", {led, level, state});
      end
    end
    rst_n = 1'b1;
  endtask
  task automatic test_ramp();
    do_reset();
    for (int n = 1; n <= 40; n++) begin
      cyc(1'b1, 1'b1);
      vectors++;
      if ({led, level, state} !== expv()) begin
        errors++;
        $display("FAIL ramp_model tick=%0d got=%h exp=%h", n, {led, level, state}, expv());
      end
      if (n == 4 || n == 6 || n == 34 || n == 38) begin
        vectors++;
        if ((n == 4 && state !== 2'd1) || (n == 6 && level !== 4'd1) ||
            (n == 34 && {level, state} !== {4'd15, 2'd2}) || (n == 38 && state !== 2'd3)) begin
          errors++;
          $display("FAIL ramp_timing tick=%0d got level=%0d state=%0d", n, level, state);
        end
      end
    end
  endtask
  task automatic test_pwm();
    int highs;
    for (int p = 0; p < 3; p++) begin
      do_reset();
      repeat (p == 0 ? 14 : p == 1 ? 34 : 0) cyc(1'b1, 1'b1);
      repeat (2) cyc(1'b1, 1'b0);
      highs = 0;
      repeat (16) begin
        cyc(1'b1, 1'b0);
        highs += int'(led);
        vectors++;
        if ({led, level, state} !== expv()) begin
          errors++;
          $display("FAIL pwm_model got=%h exp=%h", {led, level, state}, expv());
        end
      end
      vectors++;
      if (highs != (p == 0 ? 5 : p == 1 ? 15 : 0)) begin
        errors++;
        $display("FAIL pwm_duty level=%0d got=%0d exp=%0d", level, highs, p == 0 ? 5 : p == 1 ? 15 : 0);
      end
    end
  endtask
  task automatic test_enable();
    do_reset();
    repeat (18) cyc(1'b1, 1'b1);
    vectors++;
    if ({level, state} !== {4'd7, 2'd1}) begin
      errors++;
      $display("FAIL enable_setup got level=%0d state=%0d exp 7/1", level, state);
    end
    repeat (20) begin
      cyc(1'b0, 1'b1);
      vectors++;
      if ({led, level, state} !== {1'b0, 4'd7, 2'd1}) begin
        errors++;
        $display("FAIL enable_frozen got=%h exp=%h", {led, level, state}, {1'b0, 4'd7, 2'd1});
      end
    end
    cyc(1'b1, 1'b1);
    vectors++;
    if (level !== 4'd7) begin
      errors++;
      $display("FAIL enable_resume1 got=%0d exp=7", level);
    end
    cyc(1'b1, 1'b1);
    vectors++;
    if (level !== 4'd8) begin
      errors++;
      $display("FAIL enable_resume2 got=%0d exp=8", level);
    end
  endtask
  task automatic test_wrap();
    logic [1:0] hist[$];
    int bad;
    do_reset();
    for (int n = 1; n <= 160; n++) begin
      cyc(1'b1, 1'b1);
      hist.push_back(state);
      vectors++;
      if ({led, level, state} !== expv()) begin
        errors++;
        $display("FAIL wrap_model tick=%0d got=%h exp=%h", n, {led, level, state}, expv());
      end
      if (n == 67 || n == 68) begin
        vectors++;
        if ({level, state} !== (n == 67 ? {4'd1, 2'd3} : {4'd0, 2'd0})) begin
          errors++;
          $display("FAIL wrap_edge tick=%0d got level=%0d state=%0d", n, level, state);
        end
      end
    end
    bad = 0;
    for (int i = 0; i + 68 < hist.size(); i++) if (hist[i] !== hist[i + 68]) bad++;
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wrap_period got=%0d exp=0 state mismatches", bad);
    end
  endtask
  task automatic test_sparse();
    int last, changes;
    logic [3:0] prev;
    do_reset();
    last = -1;
    changes = 0;
    prev = level;
    for (int c = 0; c < 100; c++) begin
      cyc(1'b1, c % 5 == 0);
      vectors++;
      if ({led, level, state} !== expv()) begin
        errors++;
        $display("FAIL sparse_model clk=%0d got=%h exp=%h", c, {led, level, state}, expv());
      end
      if (level !== prev) begin
        changes++;
        vectors++;
        if (last >= 0 && c - last != 10) begin
          errors++;
          $display("FAIL sparse_gap got=%0d exp=10", c - last);
        end
        last = c;
        prev = level;
      end
    end
    vectors++;
    if (changes != 8) begin
      errors++;
      $display("FAIL sparse_count got=%0d exp=8", changes);
    end
  endtask
  task automatic test_random();
    do_reset();
    repeat (3000) begin
      rst_n = $urandom_range(0, 299) != 0;
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      vectors++;
      if ({led, level, state} !== expv()) begin
        errors++;
        $display("FAIL random_model got=%h exp=%h", {led, level, state}, expv());
      end
    end
    rst_n = 1'b1;
  endtask
  initial begin
    test_reset();
    test_ramp();
    test_pwm();
    test_enable();
    test_wrap();
    test_sparse();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
